line_fill_buffer: RTL and testbench
===================================

// Module: line_fill_buffer
// PURPOSE
// - Assembles one 128-bit cache line from eight 16-bit memory beats after a miss.
// - Issues the memory read critical-word-first, so the requested word arrives first.
// - Presents the requested word early on crit_word/crit_valid.
// - Presents the full line on line_out/line_valid; line_out feeds the 3-bit word-select mux and the data array.
// PARAMETERS
// - BEATS   8    words per line; offset width = $clog2(BEATS) = 3
// - WORD_W  16   bits per beat/word (lc3b_word)
// - LINE_W  128  BEATS*WORD_W; not overridable independently
// PORTS
// clk          in   1    clock, all state on rising edge
// rst_n        in   1    asynchronous, active-low reset
// fill_req     in   1    start a fill; accepted only when fill_busy=0
// fill_addr    in   16   byte address of missing word; [15:4] line, [3:1] critical offset
// fill_abort   in   1    cancel in-progress fill
// fill_busy    out  1    1 while a fill is in progress (states FILL, DONE)
// mem_read     out  1    memory read request, held for the whole burst
// mem_address  out  16   {line[15:4], crit_off, 1'b0}, stable while mem_read=1
// mem_beat     in   1    mem_rdata valid this cycle (one word per beat)
// mem_rdata    in   16   beat data
// crit_word    out  16   requested word
// crit_valid   out  1    1-cycle pulse, cycle after first beat
// line_out     out  128  assembled line; word i at [16i+15:16i]
// line_valid   out  1    1-cycle pulse when all 8 words written
// line_tag     out  12   fill_addr[15:4] of the line in line_out
// BEHAVIOUR
// - Reset: state=IDLE, count=0; mem_read, crit_valid, line_valid, fill_busy = 0.
// - Reset: line_out, crit_word, mem_address, line_tag = 0.
// - Reset mid-fill discards everything; no pulses follow.
// - IDLE:
//   - fill_req=1 latches line=fill_addr[15:4] and crit_off=fill_addr[3:1], sets count=0, goes to FILL.
//   - mem_read rises the cycle after the req edge.
//   - line_tag updates at acceptance.
// - FILL:
//   - mem_read=1.
//   - Each cycle with mem_beat=1 writes mem_rdata into slot (crit_off+count) mod 8, then count++.
//   - 3-bit add, wrap 7->0.
// - First beat (count=0): crit_word<=mem_rdata, crit_valid=1 in the next cycle only.
//   - crit_word holds until the next accepted fill.
// - Eighth beat (count=7): next state DONE; mem_read=0 from the next cycle.
// - DONE (exactly 1 cycle): line_valid=1, line_out complete; then IDLE.
//   - line_out holds until the next fill writes a slot.
// - fill_req while fill_busy=1: ignored, not queued.
// - fill_req in DONE cycle: ignored.
// - fill_abort in FILL: next state IDLE, mem_read=0 next cycle.
//   - No line_valid; crit_valid still fires if the abort coincides with the first beat.
//   - line_out keeps partial contents.
// - fill_abort in the same cycle as the 8th beat: abort wins; beat is written, no line_valid.
// - fill_abort in IDLE/DONE: no effect.
// - mem_beat outside FILL: ignored, no write.
// - Latency, back-to-back beats: req edge -> mem_read at +1; 8 beats earliest +1..+8.
//   - line_valid at +9; next fill accepted at +10.
// - Beats may have gaps (mem_beat=0); count stalls.
// TESTING
// - fill_addr=0x123A, beats 0xA000..0xA007 back-to-back -> mem_address=0x123A, crit_word=0xA000.
//   - Line words 5,6,7,0,1,2,3,4 = A000..A007; line_tag=0x123; line_valid 9 cycles after req.
// - fill_addr=0x4000 (offset 0), beats with 2-cycle gaps -> word i = beat i.
//   - line_valid exactly once, one cycle after last beat; mem_read drops the same cycle.
// - fill_abort asserted after 3 beats -> mem_read=0 next cycle, no line_valid.
//   - fill_busy=0; new fill_req accepted the following cycle.
// - fill_abort coincident with beat 8 -> no line_valid.
//   - fill_req during FILL and during DONE -> ignored, mem_address unchanged.
// - rst_n pulled low mid-fill (after 4 beats) -> all outputs 0 asynchronously, state IDLE.
//   - mem_beat pulses afterwards cause no writes.
// - fill_addr=0x00FE (offset 7) -> first beat in word 7, second in word 0 (wrap check).
//   - crit_valid a single-cycle pulse.

Source files
------------

// File: rtl/line_fill_buffer.sv
// Assembles a 128-bit line from eight 16-bit beats fetched critical-word-first.
// A fill is accepted in IDLE. mem_read follows a cycle later, and line_valid comes one cycle after the last beat. Requests arriving while busy are dropped.
module line_fill_buffer #(
  parameter int BEATS  = 8,
  parameter int WORD_W = 16,
  localparam int LINE_W = BEATS * WORD_W,
  localparam int OFF_W  = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_req,
  input  logic [15:0]       fill_addr,
  input  logic              fill_abort,
  output logic              fill_busy,
  output logic              mem_read,
  output logic [15:0]       mem_address,
  input  logic              mem_beat,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] crit_word,
  output logic              crit_valid,
  output logic [LINE_W-1:0] line_out,
  output logic              line_valid,
  output logic [14-OFF_W:0] line_tag
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [OFF_W-1:0] LAST = OFF_W'(BEATS - 1);

  state_t           state_q, state_d;
  logic [OFF_W-1:0] count_q;
  logic [OFF_W-1:0] crit_off_q;
  logic [OFF_W-1:0] slot;
  logic             accept;
  logic             beat_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    beat_wr    = 1'b0;
    fill_busy  = 1'b0;
    mem_read   = 1'b0;
    line_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_req) begin
          accept  = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        fill_busy = 1'b1;
        mem_read  = 1'b1;
        // The beat is still captured when an abort lands on the same cycle.
        beat_wr   = mem_beat;
        if (fill_abort)                        state_d = IDLE;
        else if (mem_beat && count_q == LAST)  state_d = DONE;
      end
      DONE: begin
        fill_busy  = 1'b1;
        line_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Beats arrive in wrapped order starting at the critical word.
  assign slot = crit_off_q + count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      crit_off_q  <= '0;
      mem_address <= '0;
      line_tag    <= '0;
      crit_word   <= '0;
      crit_valid  <= 1'b0;
      line_out    <= '0;
    end else begin
      crit_valid <= beat_wr && (count_q == '0);
      if (accept) begin
        count_q     <= '0;
        crit_off_q  <= fill_addr[OFF_W:1];
        mem_address <= {fill_addr[15:1], 1'b0};
        line_tag    <= fill_addr[15:OFF_W+1];
      end
      if (beat_wr) begin
        line_out[slot*WORD_W +: WORD_W] <= mem_rdata;
        count_q <= count_q + 1'b1;
        if (count_q == '0) crit_word <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed bench for line_fill_buffer with hand-computed expected lines.
module tb_line_fill_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fill_req;
  logic [15:0]  fill_addr;
  logic         fill_abort;
  logic         fill_busy;
  logic         mem_read;
  logic [15:0]  mem_address;
  logic         mem_beat;
  logic [15:0]  mem_rdata;
  logic [15:0]  crit_word;
  logic         crit_valid;
  logic [127:0] line_out;
  logic         line_valid;
  logic [11:0]  line_tag;

  int checks = 0;
  int errors = 0;
  int lv_cnt = 0;
  int cv_cnt = 0;
  int lv0;
  int cv0;

  line_fill_buffer dut (
    .clk(clk), .rst_n(rst_n), .fill_req(fill_req), .fill_addr(fill_addr),
    .fill_abort(fill_abort), .fill_busy(fill_busy), .mem_read(mem_read),
    .mem_address(mem_address), .mem_beat(mem_beat), .mem_rdata(mem_rdata),
    .crit_word(crit_word), .crit_valid(crit_valid), .line_out(line_out),
    .line_valid(line_valid), .line_tag(line_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (line_valid) lv_cnt++;
    if (crit_valid) cv_cnt++;
  endtask

  task automatic start_fill(input logic [15:0] addr);
    fill_addr = addr;
    fill_req  = 1'b1;
    cyc();
    fill_req  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fill_req = 1'b0; fill_addr = '0; fill_abort = 1'b0;
    mem_beat = 1'b0; mem_rdata = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_busy", fill_busy, 0);
    chk("rst_memrd", mem_read, 0);
    chk("rst_line", line_out, 0);
    chk("rst_addr_tag", {mem_address, line_tag, crit_word}, 0);
    chk("rst_pulses", {line_valid, crit_valid}, 0);

    // Critical-word-first fill with back-to-back beats, offset 5.
    lv0 = lv_cnt; cv0 = cv_cnt;
    start_fill(16'h123A);
    chk("t1_memrd", mem_read, 1);
    chk("t1_addr", mem_address, 16'h123A);
    chk("t1_tag", line_tag, 12'h123);
    chk("t1_busy", fill_busy, 1);
    mem_beat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_rdata = 16'(16'hA000 + i);
      fill_req  = (i == 3);
      fill_addr = (i == 3) ? 16'h5550 : 16'h123A;
      cyc();
      if (i == 0) begin
        chk("t1_cv", crit_valid, 1);
        chk("t1_cw", crit_word, 16'hA000);
      end
      if (i == 1) chk("t1_cv_pulse", crit_valid, 0);
      if (i == 4) chk("t1_req_in_fill", mem_address, 16'h123A);
    end
    chk("t1_lv_at_9", line_valid, 1);
    chk("t1_memrd_drop", mem_read, 0);
    chk("t1_line", line_out, 128'hA002_A001_A000_A007_A006_A005_A004_A003);
    mem_beat = 1'b0; fill_req = 1'b1; fill_addr = 16'h7770;
    cyc();
    fill_req = 1'b0;
    chk("t1_req_in_done", {fill_busy, mem_read}, 0);
    chk("t1_tag_hold", line_tag, 12'h123);
    chk("t1_lv_once", lv_cnt - lv0, 1);
    chk("t1_cv_once", cv_cnt - cv0, 1);

    // Offset 0 with two idle cycles between beats.
    lv0 = lv_cnt;
    start_fill(16'h4000);
    for (int i = 0; i < 8; i++) begin
      mem_beat = 1'b1; mem_rdata = 16'(16'hB000 + i);
      cyc();
      mem_beat = 1'b0;
      if (i < 7) begin cyc(); cyc(); end
    end
    chk("t2_lv", line_valid, 1);
    chk("t2_memrd", mem_read, 0);
    cyc();
    chk("t2_lv_after", line_valid, 0);
    chk("t2_lv_once", lv_cnt - lv0, 1);
    chk("t2_line", line_out, 128'hB007_B006_B005_B004_B003_B002_B001_B000);

    // Abort after three beats, then a new fill immediately.
    lv0 = lv_cnt;
    start_fill(16'h2000);
    for (int i = 0; i < 3; i++) begin
      mem_beat = 1'b1; mem_rdata = 16'(16'hC000 + i);
      cyc();
    end
    mem_beat = 1'b0; fill_abort = 1'b1;
    cyc();
    fill_abort = 1'b0;
    chk("t3_memrd", mem_read, 0);
    chk("t3_busy", fill_busy, 0);
    chk("t3_partial", line_out, 128'hB007_B006_B005_B004_B003_C002_C001_C000);
    start_fill(16'h3002);
    chk("t3_reaccept", fill_busy, 1);
    chk("t3_addr", mem_address, 16'h3002);

    // Abort coincident with the eighth beat; the beat still lands.
    for (int i = 0; i < 8; i++) begin
      mem_beat = 1'b1; mem_rdata = 16'(16'hD000 + i);
      fill_abort = (i == 7);
      cyc();
    end
    mem_beat = 1'b0; fill_abort = 1'b0;
    chk("t4_lv", line_valid, 0);
    chk("t4_idle", {fill_busy, mem_read}, 0);
    chk("t4_line", line_out, 128'hD006_D005_D004_D003_D002_D001_D000_D007);
    cyc();
    chk("t4_no_lv", lv_cnt - lv0, 0);

    // Asynchronous reset after four beats.
    start_fill(16'h6000);
    for (int i = 0; i < 4; i++) begin
      mem_beat = 1'b1; mem_rdata = 16'(16'hE000 + i);
      cyc();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ctl", {fill_busy, mem_read, line_valid, crit_valid}, 0);
    chk("t5_line", line_out, 0);
    chk("t5_regs", {mem_address, line_tag, crit_word}, 0);
    lv0 = lv_cnt;
    cyc();
    rst_n = 1'b1; mem_rdata = 16'hFFFF;
    cyc(); cyc(); cyc();
    mem_beat = 1'b0;
    chk("t5_no_write", line_out, 0);
    chk("t5_still_idle", {fill_busy, mem_read}, 0);
    chk("t5_no_lv", lv_cnt - lv0, 0);

    // Offset 7 wraps to word 0 on the second beat.
    cv0 = cv_cnt;
    start_fill(16'h00FE);
    chk("t6_addr", mem_address, 16'h00FE);
    for (int i = 0; i < 8; i++) begin
      mem_beat = 1'b1; mem_rdata = 16'((i + 1) * 16'h1111);
      cyc();
      if (i == 0) begin
        chk("t6_cv", crit_valid, 1);
        chk("t6_cw", crit_word, 16'h1111);
      end
      if (i == 1) begin
        chk("t6_cv_pulse", crit_valid, 0);
        chk("t6_wrap", line_out, 128'h1111_0000_0000_0000_0000_0000_0000_2222);
      end
    end
    mem_beat = 1'b0;
    chk("t6_lv", line_valid, 1);
    chk("t6_line", line_out, 128'h1111_8888_7777_6666_5555_4444_3333_2222);
    chk("t6_tag", line_tag, 12'h00F);
    cyc();
    chk("t6_cv_once", cv_cnt - cv0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
